// File: rtl/watch_pkg.sv
// watch_pkg: shared state encoding, BCD digit limits and target codes for the watch set logic.
package watch_pkg;
    typedef enum logic [2:0] {IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, COMMIT} state_e;
    localparam logic [3:0] H1_MAX       = 4'd2;
    localparam logic [3:0] H0_MAX       = 4'd9;
    localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
    localparam logic [3:0] M1_MAX       = 4'd5;
    localparam logic [3:0] M0_MAX       = 4'd9;
    localparam logic [1:0] DIG_H1 = 2'd3;
    localparam logic [1:0] DIG_H0 = 2'd2;
    localparam logic [1:0] DIG_M1 = 2'd1;
    localparam logic [1:0] DIG_M0 = 2'd0;
    localparam logic TGT_WATCH = 1'b0;
    localparam logic TGT_ALARM = 1'b1;
endpackage

// File: rtl/time_set_sequencer_if.sv
// time_set_sequencer_if: button inputs, captured time and edit/display/load outputs of the set sequencer.
interface time_set_sequencer_if;
    logic       set_value, next_digit, up_digit, cancel, target;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
    logic [3:0] edit_h1, edit_h0, edit_m1, edit_m0;
    logic       editing;
    logic [1:0] digit_sel;
    logic [3:0] blink_mask;
    logic       load_watch, load_alarm;
    modport master (
        output set_value, next_digit, up_digit, cancel, target, cur_h1, cur_h0, cur_m1, cur_m0,
        input  edit_h1, edit_h0, edit_m1, edit_m0, editing, digit_sel, blink_mask, load_watch, load_alarm
    );
    modport slave (
        input  set_value, next_digit, up_digit, cancel, target, cur_h1, cur_h0, cur_m1, cur_m0,
        output edit_h1, edit_h0, edit_m1, edit_m0, editing, digit_sel, blink_mask, load_watch, load_alarm
    );
endinterface

// File: rtl/button_edge.sv
// button_edge: rising-edge detector on a level button using one registered previous sample.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);
    logic prev_q;
    always_ff @(posedge clk) prev_q <= reset ? 1'b0 : in;
    assign rise = in & ~prev_q;
endmodule

// File: rtl/time_set_sequencer.sv
// time_set_sequencer: HH:MM edit-mode controller with digit cursor, legal-range wrap, blink mask and commit strobes.
module time_set_sequencer
    import watch_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input logic clk,
    input logic reset,
    time_set_sequencer_if.slave bus
);
    localparam int CW = $clog2(BLINK_DIV);
    state_e          state_q, state_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            tgt_q, tgt_d, phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            set_r, next_r, up_r, cancel_r, edit, wrap;
    logic [1:0]      sel;

    button_edge u_set    (.clk(clk), .reset(reset), .in(bus.set_value),  .rise(set_r));
    button_edge u_next   (.clk(clk), .reset(reset), .in(bus.next_digit), .rise(next_r));
    button_edge u_up     (.clk(clk), .reset(reset), .in(bus.up_digit),   .rise(up_r));
    button_edge u_cancel (.clk(clk), .reset(reset), .in(bus.cancel),     .rise(cancel_r));

    function automatic logic [3:0] inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic state_e advance(input state_e s);
        return s == EDIT_H1 ? EDIT_H0 : s == EDIT_H0 ? EDIT_M1 : s == EDIT_M1 ? EDIT_M0 : EDIT_H1;
    endfunction

    assign edit = state_q inside {EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0};
    assign sel  = state_q == EDIT_H1 ? DIG_H1 : state_q == EDIT_H0 ? DIG_H0 :
                  state_q == EDIT_M1 ? DIG_M1 : DIG_M0;
    assign wrap = cnt_q == CW'(BLINK_DIV - 1);

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        tgt_d   = tgt_q;
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        phase_d = wrap ? ~phase_q : phase_q;
        if (state_q == IDLE && set_r) begin
            state_d = EDIT_H1;
            dig_d   = {bus.cur_h1,
                       (bus.cur_h1 == H1_MAX && bus.cur_h0 > H0_MAX_AT_20) ? H0_MAX_AT_20 : bus.cur_h0,
                       bus.cur_m1, bus.cur_m0};
            tgt_d   = bus.target;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (state_q == COMMIT) begin
            state_d = IDLE;
        end else if (edit) begin
            if (set_r) begin
                state_d = COMMIT;
            end else if (cancel_r) begin
                state_d = IDLE;
            end else begin
                if (up_r) begin
                    dig_d[sel] = inc(dig_q[sel],
                                     sel == DIG_H1 ? H1_MAX :
                                     sel == DIG_H0 ? (dig_q[DIG_H1] == H1_MAX ? H0_MAX_AT_20 : H0_MAX) :
                                     sel == DIG_M1 ? M1_MAX : M0_MAX);
                    // Moving the hour tens to 2 must pull an out-of-range hour unit back to 3
                    if (sel == DIG_H1 && dig_d[DIG_H1] == H1_MAX && dig_q[DIG_H0] > H0_MAX_AT_20)
                        dig_d[DIG_H0] = H0_MAX_AT_20;
                end
                if (next_r) begin
                    state_d = advance(state_q);
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dig_q   <= '0;
            tgt_q   <= TGT_WATCH;
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            tgt_q   <= tgt_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.edit_h1    = dig_q[DIG_H1];
    assign bus.edit_h0    = dig_q[DIG_H0];
    assign bus.edit_m1    = dig_q[DIG_M1];
    assign bus.edit_m0    = dig_q[DIG_M0];
    assign bus.editing    = edit;
    assign bus.digit_sel  = edit ? sel : 2'd0;
    assign bus.blink_mask = (edit && phase_q) ? 4'b0001 << sel : 4'b0000;
    assign bus.load_watch = state_q == COMMIT && tgt_q == TGT_WATCH;
    assign bus.load_alarm = state_q == COMMIT && tgt_q == TGT_ALARM;
endmodule
